watch_top: RTL and testbench

WATCH_TOP -- requirements
Module: watch_top

---
 rtl/watch_top.sv | 184 ++++++++++++++++++
 tb/tb_watch_top.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/watch_top.sv
// Digital watch: 24 h time of day with set mode, stopwatch and countdown timer,
// driving a 4-digit multiplexed 7-segment display.
module watch_top #(
    parameter int unsigned TICK_DIV    = 100_000_000,
    parameter int unsigned REFRESH_DIV = 100_000
) (
    input  logic       clk,
    input  logic       btnC,
    input  logic       btnL,
    input  logic       btnU,
    input  logic       btnR,
    input  logic [1:0] switch,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic [3:0] thousands,
    output logic [3:0] hundreds,
    output logic [3:0] tens,
    output logic [3:0] ones
);

    typedef enum logic [1:0] {
        ModeClock     = 2'b00,
        ModeSet       = 2'b01,
        ModeStopwatch = 2'b10,
        ModeTimer     = 2'b11
    } mode_e;

    localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [TW-1:0] TICK_MAX = TW'(TICK_DIV - 1);
    localparam logic [RW-1:0] REF_MAX  = RW'(REFRESH_DIV - 1);

    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max);
        if (v == max) return 8'h00;
        if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
        return v + 8'd1;
    endfunction

    function automatic logic [7:0] bcd_dec(input logic [7:0] v);
        if (v[3:0] == 4'd0) return {v[7:4] - 4'd1, 4'd9};
        return v - 8'd1;
    endfunction

    mode_e mode;
    assign mode = mode_e'(switch);

    // Button bit order throughout: {R, U, L}
    logic [2:0] sync1_q, sync2_q, sync3_q, rise;
    logic       press_l, press_u, press_r;
    assign rise    = sync2_q & ~sync3_q;
    assign press_l = rise[0];
    assign press_u = rise[1];
    assign press_r = rise[2];

    logic [TW-1:0] tick_cnt_q;
    logic          tick;
    assign tick = (tick_cnt_q == TICK_MAX);

    logic [7:0] hrs_q, mins_q, secs_q;
    logic [7:0] sw_min_q, sw_sec_q, tm_min_q, tm_sec_q;
    logic       sw_run_q, tm_run_q, tm_zero;
    assign tm_zero = (tm_min_q == 8'h00) && (tm_sec_q == 8'h00);

    logic [RW-1:0] ref_cnt_q;
    logic [1:0]    slot_q;

    always_ff @(posedge clk) begin
        if (btnC) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            sync3_q    <= '0;
            tick_cnt_q <= '0;
        end else begin
            sync1_q    <= {btnR, btnU, btnL};
            sync2_q    <= sync1_q;
            sync3_q    <= sync2_q;
            tick_cnt_q <= tick ? '0 : tick_cnt_q + TW'(1);
        end
    end

    // Time of day: frozen and editable in set mode, running otherwise.
    always_ff @(posedge clk) begin
        if (btnC) begin
            hrs_q  <= 8'h00;
            mins_q <= 8'h00;
            secs_q <= 8'h00;
        end else if (mode == ModeSet) begin
            if (press_l) hrs_q <= bcd_inc(hrs_q, 8'h23);
            if (press_u) mins_q <= bcd_inc(mins_q, 8'h59);
            if (press_l || press_u) secs_q <= 8'h00;
        end else if (tick) begin
            secs_q <= bcd_inc(secs_q, 8'h59);
            if (secs_q == 8'h59) begin
                mins_q <= bcd_inc(mins_q, 8'h59);
                if (mins_q == 8'h59) hrs_q <= bcd_inc(hrs_q, 8'h23);
            end
        end
    end

    // Toggles use the old run flag for a coincident tick; clear overrides the tick.
    always_ff @(posedge clk) begin
        if (btnC || (mode == ModeStopwatch && press_r)) begin
            sw_min_q <= 8'h00;
            sw_sec_q <= 8'h00;
            sw_run_q <= 1'b0;
        end else begin
            if (mode == ModeStopwatch && press_l) sw_run_q <= ~sw_run_q;
            if (tick && sw_run_q) begin
                sw_sec_q <= bcd_inc(sw_sec_q, 8'h59);
                if (sw_sec_q == 8'h59) sw_min_q <= bcd_inc(sw_min_q, 8'h59);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (btnC || (mode == ModeTimer && press_r)) begin
            tm_min_q <= 8'h00;
            tm_sec_q <= 8'h00;
            tm_run_q <= 1'b0;
        end else begin
            if (mode == ModeTimer && press_u && !tm_run_q) tm_min_q <= bcd_inc(tm_min_q, 8'h59);
            if (mode == ModeTimer && press_l && !tm_zero) tm_run_q <= ~tm_run_q;
            if (tick && tm_run_q) begin
                if (tm_sec_q == 8'h00) begin
                    tm_sec_q <= 8'h59;
                    tm_min_q <= bcd_dec(tm_min_q);
                end else begin
                    tm_sec_q <= bcd_dec(tm_sec_q);
                end
                if (tm_min_q == 8'h00 && tm_sec_q == 8'h01) tm_run_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (btnC) begin
            {thousands, hundreds, tens, ones} <= 16'h0000;
        end else begin
            unique case (mode)
                ModeClock, ModeSet: {thousands, hundreds, tens, ones} <= {hrs_q, mins_q};
                ModeStopwatch:      {thousands, hundreds, tens, ones} <= {sw_min_q, sw_sec_q};
                ModeTimer:          {thousands, hundreds, tens, ones} <= {tm_min_q, tm_sec_q};
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (btnC) begin
            ref_cnt_q <= '0;
            slot_q    <= 2'd0;
        end else if (ref_cnt_q == REF_MAX) begin
            ref_cnt_q <= '0;
            slot_q    <= slot_q + 2'd1;
        end else begin
            ref_cnt_q <= ref_cnt_q + RW'(1);
        end
    end

    logic [3:0] digit;
    always_comb begin
        an    = 4'b1110;
        digit = ones;
        unique case (slot_q)
            2'd0: begin an = 4'b1110; digit = ones;      end
            2'd1: begin an = 4'b1101; digit = tens;      end
            2'd2: begin an = 4'b1011; digit = hundreds;  end
            2'd3: begin an = 4'b0111; digit = thousands; end
        endcase
        case (digit)
            4'd0:    seg = 7'b1000000;
            4'd1:    seg = 7'b1111001;
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            4'd7:    seg = 7'b1111000;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0010000;
            default: seg = 7'b1111111;
        endcase
    end

endmodule

// File: tb/tb_watch_top.sv
// Scoreboard bench for watch_top with TICK_DIV=4, REFRESH_DIV=2; stimulus stays
// aligned so every sample lands two cycles after a tick edge.
module tb_watch_top;

    localparam logic [2:0] BL = 3'b001;
    localparam logic [2:0] BU = 3'b010;
    localparam logic [2:0] BR = 3'b100;

    logic       clk = 1'b0;
    logic       btnC, btnL, btnU, btnR;
    logic [1:0] switch;
    logic [6:0] seg;
    logic [3:0] an, thousands, hundreds, tens, ones;
    logic [15:0] got_d, exp_d;
    logic [15:0] sb[$];
    int errors = 0;
    int checks = 0;

    assign got_d = {thousands, hundreds, tens, ones};

    watch_top #(.TICK_DIV(4), .REFRESH_DIV(2)) dut (
        .clk(clk), .btnC(btnC), .btnL(btnL), .btnU(btnU), .btnR(btnR), .switch(switch),
        .seg(seg), .an(an), .thousands(thousands), .hundreds(hundreds), .tens(tens),
        .ones(ones)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] seg_code(input logic [3:0] d);
        case (d)
            4'd0: return 7'b1000000;  4'd1: return 7'b1111001;
            4'd2: return 7'b0100100;  4'd3: return 7'b0110000;
            4'd4: return 7'b0011001;  4'd5: return 7'b0010010;
            4'd6: return 7'b0000010;  4'd7: return 7'b1111000;
            4'd8: return 7'b0000000;  4'd9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic ticks(input int n);
        cycles(4 * n);
    endtask

    // One-cycle press, four cycles total; acts two cycles after a tick edge.
    task automatic presses(input logic [2:0] m, input int n);
        for (int i = 0; i < n; i++) begin
            {btnR, btnU, btnL} = m;
            cycles(1);
            {btnR, btnU, btnL} = 3'b000;
            cycles(3);
        end
    endtask

    // Eight cycles; the press acts on the same edge as a tick.
    task automatic press_at_tick(input logic [2:0] m);
        cycles(3);
        {btnR, btnU, btnL} = m;
        cycles(1);
        {btnR, btnU, btnL} = 3'b000;
        cycles(4);
    endtask

    task automatic test_reset;
        btnC = 1'b1; {btnR, btnU, btnL} = 3'b000; switch = 2'b00;
        cycles(3);
        sb.push_back(16'h0000);
        exp_d = sb.pop_front(); checks++;
        if (got_d !== exp_d) begin errors++; $display("FAIL reset_digits got=%h exp=%h", got_d, exp_d); end
        checks++;
        if (an !== 4'b1110) begin errors++; $display("FAIL reset_an got=%b exp=1110", an); end
        checks++;
        if (seg !== 7'b1000000) begin errors++; $display("FAIL reset_seg got=%b exp=1000000", seg); end
        btnC = 1'b0;
        cycles(2);
    endtask

    task automatic test_clock;
        sb.push_back(16'h0004); ticks(240);
        exp_d = sb.pop_front(); checks++;
        if (got_d !== exp_d) begin errors++; $display("FAIL clock_240_ticks got=%h exp=%h", got_d, exp_d); end
        switch = 2'b01; presses(BL, 23); presses(BU, 55);
        sb.push_back(16'h2359);
        exp_d = sb.pop_front(); checks++;
        if (got_d !== exp_d) begin errors++; $display("FAIL set_23_59 got=%h exp=%h", got_d, exp_d); end
        switch = 2'b00; sb.push_back(16'h2359); ticks(59);
        exp_d = sb.pop_front(); checks++;
        if (got_d !== exp_d) begin errors++; $display("FAIL clock_23_59_59 got=%h exp=%h", got_d, exp_d); end
        sb.push_back(16'h0000); ticks(1);
        exp_d = sb.pop_front(); checks++;
        if (got_d !== exp_d) begin errors++; $display("FAIL clock_wrap got=%h exp=%h", got_d, exp_d); end
    endtask

    task automatic test_set_hold;
        ticks(30);
        switch = 2'b01; btnU = 1'b1; cycles(50); btnU = 1'b0; cycles(2);
        sb.push_back(16'h0001);
        exp_d = sb.pop_front(); checks++;
        if (got_d !== exp_d) begin errors++; $display("FAIL set_hold_once got=%h exp=%h", got_d, exp_d); end
        sb.push_back(16'h0001); ticks(64);
        exp_d = sb.pop_front(); checks++;
        if (got_d !== exp_d) begin errors++; $display("FAIL set_frozen got=%h exp=%h", got_d, exp_d); end
        switch = 2'b00; sb.push_back(16'h0001); ticks(59);
        exp_d = sb.pop_front(); checks++;
        if (got_d !== exp_d) begin errors++; $display("FAIL set_secs_cleared_a got=%h exp=%h", got_d, exp_d); end
        sb.push_back(16'h0002); ticks(1);
        exp_d = sb.pop_front(); checks++;
        if (got_d !== exp_d) begin errors++; $display("FAIL set_secs_cleared_b got=%h exp=%h", got_d, exp_d); end
    endtask

    task automatic test_set_hours;
        switch = 2'b01; presses(BL, 24); sb.push_back(16'h0002);
        exp_d = sb.pop_front(); checks++;
        if (got_d !== exp_d) begin errors++; $display("FAIL hours_wrap_24 got=%h exp=%h", got_d, exp_d); end
        presses(BL, 1); sb.push_back(16'h0102);
        exp_d = sb.pop_front(); checks++;
        if (got_d !== exp_d) begin errors++; $display("FAIL hours_25 got=%h exp=%h", got_d, exp_d); end
        switch = 2'b00; presses(BL, 1); presses(BU, 1); presses(BR, 1); sb.push_back(16'h0102);
        exp_d = sb.pop_front(); checks++;
        if (got_d !== exp_d) begin errors++; $display("FAIL clock_ignores_buttons got=%h exp=%h", got_d, exp_d); end
    endtask

    task automatic test_stopwatch;
        switch = 2'b10; presses(BL, 1); sb.push_back(16'h0101); ticks(61);
        exp_d = sb.pop_front(); checks++;
        if (got_d !== exp_d) begin errors++; $display("FAIL sw_61_ticks got=%h exp=%h", got_d, exp_d); end
        presses(BL, 1); sb.push_back(16'h0102); ticks(10);
        exp_d = sb.pop_front(); checks++;
        if (got_d !== exp_d) begin errors++; $display("FAIL sw_stop_hold got=%h exp=%h", got_d, exp_d); end
        presses(BR, 1); sb.push_back(16'h0000); ticks(5);
        exp_d = sb.pop_front(); checks++;
        if (got_d !== exp_d) begin errors++; $display("FAIL sw_clear got=%h exp=%h", got_d, exp_d); end
        presses(BL, 1); switch = 2'b00; ticks(10); switch = 2'b10;
        sb.push_back(16'h0011); ticks(1);
        exp_d = sb.pop_front(); checks++;
        if (got_d !== exp_d) begin errors++; $display("FAIL sw_runs_other_modes got=%h exp=%h", got_d, exp_d); end
        press_at_tick(BR); sb.push_back(16'h0000); ticks(3);
        exp_d = sb.pop_front(); checks++;
        if (got_d !== exp_d) begin errors++; $display("FAIL sw_clear_beats_tick got=%h exp=%h", got_d, exp_d); end
        press_at_tick(BL); sb.push_back(16'h0002); ticks(2);
        exp_d = sb.pop_front(); checks++;
        if (got_d !== exp_d) begin errors++; $display("FAIL sw_toggle_next_tick got=%h exp=%h", got_d, exp_d); end
        presses(BR, 1);
    endtask

    task automatic test_timer;
        switch = 2'b11; presses(BL, 1); sb.push_back(16'h0000); ticks(2);
        exp_d = sb.pop_front(); checks++;
        if (got_d !== exp_d) begin errors++; $display("FAIL tm_start_ignored_zero got=%h exp=%h", got_d, exp_d); end
        presses(BU, 1); sb.push_back(16'h0100); ticks(3);
        exp_d = sb.pop_front(); checks++;
        if (got_d !== exp_d) begin errors++; $display("FAIL tm_set_min got=%h exp=%h", got_d, exp_d); end
        presses(BL, 1); sb.push_back(16'h0059); ticks(1);
        exp_d = sb.pop_front(); checks++;
        if (got_d !== exp_d) begin errors++; $display("FAIL tm_first_tick got=%h exp=%h", got_d, exp_d); end
        sb.push_back(16'h0000); ticks(59);
        exp_d = sb.pop_front(); checks++;
        if (got_d !== exp_d) begin errors++; $display("FAIL tm_reach_zero got=%h exp=%h", got_d, exp_d); end
        sb.push_back(16'h0000); ticks(5);
        exp_d = sb.pop_front(); checks++;
        if (got_d !== exp_d) begin errors++; $display("FAIL tm_stays_zero got=%h exp=%h", got_d, exp_d); end
        presses(BU, 1); sb.push_back(16'h0100); ticks(2);
        exp_d = sb.pop_front(); checks++;
        if (got_d !== exp_d) begin errors++; $display("FAIL tm_stopped_after_zero got=%h exp=%h", got_d, exp_d); end
        presses(BL, 1); sb.push_back(16'h0058); ticks(2);
        exp_d = sb.pop_front(); checks++;
        if (got_d !== exp_d) begin errors++; $display("FAIL tm_running got=%h exp=%h", got_d, exp_d); end
        presses(BU, 1); sb.push_back(16'h0057);
        exp_d = sb.pop_front(); checks++;
        if (got_d !== exp_d) begin errors++; $display("FAIL tm_min_ignored_running got=%h exp=%h", got_d, exp_d); end
        presses(BR, 1); sb.push_back(16'h0000); ticks(2);
        exp_d = sb.pop_front(); checks++;
        if (got_d !== exp_d) begin errors++; $display("FAIL tm_clear got=%h exp=%h", got_d, exp_d); end
    endtask

    task automatic test_reset_mid;
        switch = 2'b10; presses(BL, 1); ticks(4); presses(BL, 1);
        sb.push_back(16'h0005);
        exp_d = sb.pop_front(); checks++;
        if (got_d !== exp_d) begin errors++; $display("FAIL sw_before_reset got=%h exp=%h", got_d, exp_d); end
        // btnL edge lands on the same edge as the reset pulse.
        btnL = 1'b1; cycles(1); btnL = 1'b0; cycles(1);
        btnC = 1'b1; cycles(1); btnC = 1'b0; cycles(2);
        sb.push_back(16'h0000);
        exp_d = sb.pop_front(); checks++;
        if (got_d !== exp_d) begin errors++; $display("FAIL reset_mid_digits got=%h exp=%h", got_d, exp_d); end
        sb.push_back(16'h0000); ticks(3);
        exp_d = sb.pop_front(); checks++;
        if (got_d !== exp_d) begin errors++; $display("FAIL reset_beats_button got=%h exp=%h", got_d, exp_d); end
        switch = 2'b00; sb.push_back(16'h0000); ticks(1);
        exp_d = sb.pop_front(); checks++;
        if (got_d !== exp_d) begin errors++; $display("FAIL reset_clears_time got=%h exp=%h", got_d, exp_d); end
    endtask

    task automatic test_scan;
        logic [3:0] an_seq [8] = '{4'b1110, 4'b1101, 4'b1101, 4'b1011,
                                   4'b1011, 4'b0111, 4'b0111, 4'b1110};
        switch = 2'b00; btnC = 1'b1; cycles(2); btnC = 1'b0;
        for (int i = 0; i < 8; i++) sb.push_back({12'h000, an_seq[i]});
        for (int i = 0; i < 8; i++) begin
            cycles(1);
            exp_d = sb.pop_front(); checks++;
            if (an !== exp_d[3:0]) begin errors++; $display("FAIL scan_an[%0d] got=%b exp=%b", i, an, exp_d[3:0]); end
            checks++;
            if (seg !== 7'b1000000) begin errors++; $display("FAIL scan_seg[%0d] got=%b exp=1000000", i, seg); end
        end
        cycles(2);
        checks++;
        if (an !== 4'b1101) begin errors++; $display("FAIL scan_pre_reset got=%b exp=1101", an); end
        btnC = 1'b1; cycles(1);
        checks++;
        if (an !== 4'b1110) begin errors++; $display("FAIL scan_reset_an got=%b exp=1110", an); end
        btnC = 1'b0; cycles(2);
    endtask

    task automatic test_seg_decode;
        logic [3:0] d;
        for (int p = 0; p < 3; p++) begin
            case (p)
                0: begin switch = 2'b01; presses(BL, 14); presses(BU, 29); sb.push_back(16'h1429); end
                1: begin switch = 2'b11; presses(BU, 38); sb.push_back(16'h3800); end
                default: begin presses(BL, 1); ticks(3); presses(BL, 1); sb.push_back(16'h3756); end
            endcase
            exp_d = sb.pop_front(); checks++;
            if (got_d !== exp_d) begin errors++; $display("FAIL seg_digits[%0d] got=%h exp=%h", p, got_d, exp_d); end
            for (int i = 0; i < 8; i++) begin
                cycles(1);
                d = 4'hf;
                case (an)
                    4'b1110: d = exp_d[3:0];
                    4'b1101: d = exp_d[7:4];
                    4'b1011: d = exp_d[11:8];
                    4'b0111: d = exp_d[15:12];
                    default: begin errors++; $display("FAIL seg_an_legal got=%b exp=one-low", an); end
                endcase
                checks++;
                if (seg !== seg_code(d)) begin
                    errors++;
                    $display("FAIL seg_code[%0d.%0d] got=%b exp=%b", p, i, seg, seg_code(d));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_clock();
        test_set_hold();
        test_set_hours();
        test_stopwatch();
        test_timer();
        test_reset_mid();
        test_scan();
        test_seg_decode();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
